scp_control_fsm: RTL
====================

// Module: scp_control_fsm
// PURPOSE
//  Multi-cycle Moore controller that sequences the 8-bit single-cycle-processor datapath (PC, accumulator, ALU, I/O mux).
//  Consumes the 3-bit opCode decoded by the datapath.
//  Produces every datapath strobe: start, rd, wr, LoadAcc, AcSel, AddSub, Shift, IOMemSel.
//  Adds data-memory wait states, a run/halt handshake and a retired-instruction counter.
// PARAMETERS
//  RD_WAIT    1  extra cycles rd is held before data is taken (0..7)
//  ICNT_W     8  width of the retired-instruction counter
// PORTS
//  clk       in   1       single clock, all logic on rising edge
//  reset     in   1       synchronous, active-low; sampled on rising clk
//  run       in   1       level: 1 = execute program, 0 = finish current instr then IDLE
//  opCode    in   3       instruction class from datapath
//  start     out  1       PC advance/enable strobe to datapath
//  rd        out  1       data-memory read strobe (drives DM address select)
//  wr        out  1       DM_Dinbus latch enable
//  LoadAcc   out  1       accumulator load enable
//  AcSel     out  1       1 = ALU result to acc, 0 = DM_Doutbus to acc
//  AddSub    out  1       ALU op: 0 add, 1 subtract
//  Shift     out  1       ALU shift-left select
//  IOMemSel  out  1       1 = DataIn to DM_Dinbus, 0 = AcOut
//  busy      out  1       1 in any state other than IDLE/HALT
//  halted    out  1       1 in HALT
//  icount    out  ICNT_W  retired-instruction count
// BEHAVIOUR
//  Opcodes:
//   000 LDA, 001 STA, 010 ADD, 011 SUB, 100 SHL, 101 INP, 110 NOP, 111 HLT.
//  Outputs are registered (Moore on next state); no combinational input->output path.
//  Reset (reset==0 at edge): state=IDLE, all outputs 0, icount=0.
//   Reset mid-instruction aborts it; no strobe survives into the next cycle.
//  IDLE: outputs 0.
//   run=1 -> FETCH.
//  FETCH: start=1 for exactly 1 cycle -> DECODE.
//  DECODE: 1 cycle, opCode sampled into an internal register.
//   LDA/ADD/SUB/SHL -> MEMRD; STA/INP -> MEMWR; NOP -> RETIRE; HLT -> HALT.
//   Later opCode changes are ignored until the next DECODE.
//  MEMRD: rd=1 for RD_WAIT+1 cycles (wait counter) -> EXEC.
//  EXEC: rd=1, LoadAcc=1 for 1 cycle.
//   LDA: AcSel=0.
//   ADD: AcSel=1, AddSub=0.
//   SUB: AcSel=1, AddSub=1.
//   SHL: AcSel=1, Shift=1.
//   Then -> RETIRE.
//  MEMWR: wr=1 for 1 cycle; IOMemSel=1 for INP, 0 for STA -> RETIRE.
//   IOMemSel is set 1 cycle before wr and held through wr (setup margin).
//  RETIRE: icount+1, wrapping modulo 2^ICNT_W (0xFF -> 0x00 for default).
//   run=1 -> FETCH; run=0 -> IDLE.
//  HALT: halted=1, busy=0; icount includes the HLT instruction.
//   Leaves only via reset; run is ignored.
//  Invariants:
//   - wr and LoadAcc are never 1 in the same cycle.
//   - start is never 1 while rd or wr is 1.
//   - AddSub and Shift are 0 outside EXEC.
//  run dropping mid-instruction does not truncate it; the controller returns to IDLE only from RETIRE.
//  Per-instruction latency: LDA/ALU = 4+RD_WAIT+1 cycles, STA/INP = 4, NOP = 3.
//   Counted from FETCH through RETIRE inclusive.
// STRUCTURE
//  Shared package scp_pkg: opcode localparams (OP_LDA..OP_HLT) and the state encoding
//   (IDLE, FETCH, DECODE, MEMRD, EXEC, MEMWR, RETIRE, HALT).
//  Sub-module scp_wait_cnt: loadable down-counter for the MEMRD wait states.
//  Everything else stays in this file: FSM, decode, output registers, icount.
// TESTING
//  1. Hold reset=0 for 3 clks with run=1 -> every output 0, icount=0.
//     Release -> start=1 on the 2nd edge after release.
//  2. RD_WAIT=1, run=1, opCode=010 (ADD) -> start, then decode, then rd=1 x2 cycles,
//     then rd=LoadAcc=AcSel=1 with AddSub=0, then icount=1.
//  3. opCode=101 (INP) -> IOMemSel=1 one cycle before wr=1 and during wr=1; LoadAcc stays 0.
//     Then opCode=001 (STA) -> wr=1 with IOMemSel=0.
//  4. Stream NOP x256 with run=1 -> icount wraps 0xFF -> 0x00; busy stays 1 throughout.
//  5. opCode=111 -> halted=1 and stays 1 for 20 clks with run toggling.
//     reset=0 -> halted=0, state IDLE.
//  6. Drop run during MEMRD of a SUB -> the instruction completes (AddSub=1 in EXEC), icount+1, then IDLE.
//     Separately, assert reset=0 during EXEC -> LoadAcc=0 on the next cycle.

Source files
------------

// File: rtl/scp_pkg.sv
// Shared definitions for the single-cycle-processor controller.
// Holds the opcode values decoded by the datapath, the controller state
// encoding, the bundle of registered datapath strobes and small opcode
// classification helpers used by the FSM.
package scp_pkg;

  // Instruction classes delivered by the datapath on opCode
  localparam logic [2:0] OP_LDA = 3'b000;
  localparam logic [2:0] OP_STA = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_INP = 3'b101;
  localparam logic [2:0] OP_NOP = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  // Width of the MEMRD wait-state counter (covers 0..7 extra cycles)
  localparam int WAIT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMRD,
    S_EXEC,
    S_MEMWR,
    S_RETIRE,
    S_HALT
  } state_t;

  // Every strobe the controller registers toward the datapath
  typedef struct packed {
    logic start;
    logic rd;
    logic wr;
    logic load_acc;
    logic ac_sel;
    logic add_sub;
    logic shift;
    logic io_mem_sel;
    logic busy;
    logic halted;
  } ctrl_t;

  // Instructions that need a data-memory read followed by an accumulator load
  function automatic logic is_mem_read(input logic [2:0] op);
    logic hit;
    hit = 1'b0;
    case (op)
      OP_LDA, OP_ADD, OP_SUB, OP_SHL: hit = 1'b1;
      default:                        hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Instructions that write DM_Dinbus
  function automatic logic is_mem_write(input logic [2:0] op);
    logic hit;
    hit = 1'b0;
    case (op)
      OP_STA, OP_INP: hit = 1'b1;
      default:        hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/scp_wait_cnt.sv
// Loadable down-counter that times the data-memory read wait states.
// Ports:
//   clk       in  rising-edge clock
//   reset     in  synchronous active-low reset
//   load      in  load load_val (takes priority over dec)
//   load_val  in  WAIT_W-bit value to load
//   dec       in  count down by one, saturating at zero
//   zero      out count has reached zero
module scp_wait_cnt
  import scp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              dec,
  output logic              zero
);

  logic [WAIT_W-1:0] count_q;
  logic [WAIT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/scp_control_fsm.sv
// Multi-cycle Moore controller for the 8-bit single-cycle-processor
// datapath. It walks each instruction through FETCH, DECODE, an optional
// memory read (with wait states) or write phase, and RETIRE, producing all
// datapath strobes from registers so no input reaches an output
// combinationally. It also provides a run/halt handshake and a
// retired-instruction counter.
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-low reset
//   run       in   level; 1 = execute, 0 = finish current instruction then idle
//   opCode    in   3-bit instruction class from the datapath
//   start     out  PC advance/enable strobe
//   rd        out  data-memory read strobe
//   wr        out  DM_Dinbus latch enable
//   LoadAcc   out  accumulator load enable
//   AcSel     out  1 = ALU result to acc, 0 = DM_Doutbus to acc
//   AddSub    out  ALU op: 0 add, 1 subtract
//   Shift     out  ALU shift-left select
//   IOMemSel  out  1 = DataIn to DM_Dinbus, 0 = AcOut
//   busy      out  1 in any state other than IDLE/HALT
//   halted    out  1 in HALT
//   icount    out  retired-instruction count (wraps)
module scp_control_fsm
  import scp_pkg::*;
#(
  parameter int RD_WAIT = 1,
  parameter int ICNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [2:0]        opCode,
  output logic              start,
  output logic              rd,
  output logic              wr,
  output logic              LoadAcc,
  output logic              AcSel,
  output logic              AddSub,
  output logic              Shift,
  output logic              IOMemSel,
  output logic              busy,
  output logic              halted,
  output logic [ICNT_W-1:0] icount
);

  localparam logic [WAIT_W-1:0] RD_WAIT_V = WAIT_W'(RD_WAIT);
  localparam logic [ICNT_W-1:0] ICNT_ONE  = ICNT_W'(1);

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [ICNT_W-1:0] icount_q, icount_d;
  logic              run_q, run_d;

  logic wait_load;
  logic wait_dec;
  logic wait_zero;

  scp_wait_cnt u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (wait_load),
    .load_val (RD_WAIT_V),
    .dec      (wait_dec),
    .zero     (wait_zero)
  );

  // run is registered first so the FSM only sees a clean level; this is
  // why the first FETCH after reset release appears on the second edge.
  always_comb begin
    run_d = run;
  end

  // Next-state logic. The opcode is captured on the edge that enters
  // DECODE and held until the next DECODE, so the datapath may change
  // opCode freely while an instruction is in flight.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wait_load = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run_q) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_DECODE;
        op_d    = opCode;
      end
      S_DECODE: begin
        if (op_q == OP_HLT) begin
          state_d = S_HALT;
        end else if (op_q == OP_NOP) begin
          state_d = S_RETIRE;
        end else if (is_mem_write(op_q)) begin
          state_d = S_MEMWR;
        end else begin
          state_d   = S_MEMRD;
          wait_load = 1'b1;
        end
      end
      S_MEMRD: begin
        if (wait_zero) state_d = S_EXEC;
      end
      S_EXEC:   state_d = S_RETIRE;
      S_MEMWR:  state_d = S_RETIRE;
      S_RETIRE: state_d = run_q ? S_FETCH : S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  assign wait_dec = (state_q == S_MEMRD);

  // Output strobes are decoded from the state being entered so that the
  // registered outputs line up with the state register. IOMemSel is raised
  // already in DECODE for INP to give DM_Dinbus a cycle of setup before wr.
  always_comb begin
    ctrl_d = '0;
    unique case (state_d)
      S_FETCH: begin
        ctrl_d.start = 1'b1;
      end
      S_DECODE: begin
        ctrl_d.io_mem_sel = (op_d == OP_INP);
      end
      S_MEMRD: begin
        ctrl_d.rd = 1'b1;
      end
      S_EXEC: begin
        ctrl_d.rd       = 1'b1;
        ctrl_d.load_acc = 1'b1;
        ctrl_d.ac_sel   = is_mem_read(op_d) && (op_d != OP_LDA);
        ctrl_d.add_sub  = (op_d == OP_SUB);
        ctrl_d.shift    = (op_d == OP_SHL);
      end
      S_MEMWR: begin
        ctrl_d.wr         = 1'b1;
        ctrl_d.io_mem_sel = (op_d == OP_INP);
      end
      S_HALT: begin
        ctrl_d.halted = 1'b1;
      end
      default: begin
        ctrl_d = '0;
      end
    endcase
    ctrl_d.busy = (state_d != S_IDLE) && (state_d != S_HALT);
  end

  // The retire count covers both normal retirement and the HLT
  // instruction itself, which never passes through RETIRE.
  always_comb begin
    icount_d = icount_q;
    if ((state_d == S_RETIRE) || ((state_d == S_HALT) && (state_q != S_HALT))) begin
      icount_d = icount_q + ICNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_LDA;
      ctrl_q   <= '0;
      icount_q <= '0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ctrl_q   <= ctrl_d;
      icount_q <= icount_d;
      run_q    <= run_d;
    end
  end

  assign start    = ctrl_q.start;
  assign rd       = ctrl_q.rd;
  assign wr       = ctrl_q.wr;
  assign LoadAcc  = ctrl_q.load_acc;
  assign AcSel    = ctrl_q.ac_sel;
  assign AddSub   = ctrl_q.add_sub;
  assign Shift    = ctrl_q.shift;
  assign IOMemSel = ctrl_q.io_mem_sel;
  assign busy     = ctrl_q.busy;
  assign halted   = ctrl_q.halted;
  assign icount   = icount_q;

endmodule
